// File: rtl/stream_group_sum_pkg.sv
// Shared types and helpers for the stream_group_sum stage.
package stream_group_sum_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Counter width that stays at least one bit for degenerate ranges.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_group_sum_if.sv
// Start/done handshake plus element input and sum output streams.
interface stream_group_sum_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sIn;
  logic         sIn_valid;
  logic         sIn_ready;
  logic [N-1:0] sOut;
  logic         sOut_valid;
  logic         sOut_ready;

  modport master (
    output in_valid, out_ready, sIn, sIn_valid, sOut_ready,
    input  in_ready, out_valid, sIn_ready, sOut, sOut_valid
  );

  modport slave (
    input  in_valid, out_ready, sIn, sIn_valid, sOut_ready,
    output in_ready, out_valid, sIn_ready, sOut, sOut_valid
  );
endinterface

// File: rtl/stream_group_sum_out_reg.sv
// Single-entry valid/ready holding register; a load wins over a drain so a
// same-cycle drain and reload keeps valid high with the new value.
module stream_group_sum_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/stream_group_sum.sv
// Sums consecutive groups of LEN elements and emits one sum per group;
// after GROUPS sums it signals done (GROUPS=0 runs forever).
//
//   state   | meaning
//   ST_IDLE | waiting for a start request, in_ready high
//   ST_RUN  | consuming elements and producing group sums
//   ST_DONE | last sum loaded; done raised once it has drained
module stream_group_sum
  import stream_group_sum_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int LEN    = 2,
  parameter int GROUPS = 4
) (
  input logic               clk,
  input logic               rst,
  stream_group_sum_if.slave bus
);
  localparam int CNT_W = width_min1(LEN);
  localparam int GRP_W = width_min1(GROUPS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);

  state_e           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GRP_W-1:0] grp_q, grp_d;

  logic         is_final;
  logic         sin_ready;
  logic         fire_in;
  logic         load_out;
  logic         sout_valid;
  logic         done_valid;
  logic [N-1:0] sum_w;

  assign is_final  = (cnt_q == CNT_LAST);
  assign sum_w     = acc_q + bus.sIn;
  // Only a final element needs room in the output register.
  assign sin_ready = (state_q == ST_RUN) & (~is_final | ~sout_valid | bus.sOut_ready);
  assign fire_in   = sin_ready & bus.sIn_valid;
  assign load_out  = fire_in & is_final;
  assign done_valid = (state_q == ST_DONE) & ~sout_valid;

  assign bus.sIn_ready  = sin_ready;
  assign bus.sOut_valid = sout_valid;
  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = done_valid;

  stream_group_sum_out_reg #(
    .W(N)
  ) u_out_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_out),
    .data_i (sum_w),
    .ready_i(bus.sOut_ready),
    .valid_o(sout_valid),
    .data_o (bus.sOut)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    grp_d   = grp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_RUN;
          acc_d   = '0;
          cnt_d   = '0;
          grp_d   = '0;
        end
      end
      ST_RUN: begin
        if (fire_in) begin
          if (is_final) begin
            acc_d = '0;
            cnt_d = '0;
            grp_d = grp_q + GRP_W'(1);
            if ((GROUPS != 0) && (grp_q == GRP_LAST)) state_d = ST_DONE;
          end else begin
            acc_d = sum_w;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (done_valid && bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      grp_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      grp_q   <= grp_d;
    end
  end
endmodule

// File: tb/tb_stream_group_sum.sv
// Bench for stream_group_sum: directed scenarios plus randomized runs against
// a queue-based reference model; a second instance covers LEN=1, GROUPS=0.
module tb_stream_group_sum;
  localparam int N      = 8;
  localparam int LEN    = 2;
  localparam int GROUPS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_c;

  stream_group_sum_if #(.N(N)) ifa ();
  stream_group_sum_if #(.N(N)) ifc ();

  stream_group_sum #(.N(N), .LEN(LEN), .GROUPS(GROUPS)) u_dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa.slave)
  );

  stream_group_sum #(.N(N), .LEN(1), .GROUPS(0)) u_dut_c (
    .clk(clk), .rst(rst_c), .bus(ifc.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 running, 2 all sums produced.
  int m_phase, m_idx, m_acc, m_produced;
  int exp_q[$];
  int taken_q[$];
  int feed_q[$];
  bit a_fire_in;

  task automatic a_model_reset();
    m_phase    = 0;
    m_idx      = 0;
    m_acc      = 0;
    m_produced = 0;
    exp_q.delete();
    a_fire_in  = 1'b0;
  endtask

  // One clock of instance A: check outputs at negedge, then advance the model.
  task automatic a_cycle();
    bit exp_rdy, exp_ov, fire_out, start, ack;
    int x;
    @(negedge clk);
    if (rst_a) begin
      @(posedge clk);
      a_model_reset();
      #1;
    end else begin
      exp_ov  = (m_phase == 2) && (exp_q.size() == 0);
      exp_rdy = (m_phase == 1) && ((m_idx != LEN - 1) || (exp_q.size() == 0) || ifa.sOut_ready);
      check("in_ready", ifa.in_ready, m_phase == 0);
      check("out_valid", ifa.out_valid, exp_ov);
      check("sIn_ready", ifa.sIn_ready, exp_rdy);
      check("sOut_valid", ifa.sOut_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) check("sOut", ifa.sOut, exp_q[0]);
      fire_out  = (exp_q.size() > 0) && ifa.sOut_ready;
      a_fire_in = exp_rdy && ifa.sIn_valid;
      start     = (m_phase == 0) && ifa.in_valid;
      ack       = exp_ov && ifa.out_ready;
      x         = int'(ifa.sIn);
      @(posedge clk);
      if (fire_out) taken_q.push_back(exp_q.pop_front());
      if (a_fire_in) begin
        m_acc = (m_acc + x) % 256;
        m_idx++;
        if (m_idx == LEN) begin
          exp_q.push_back(m_acc);
          m_acc = 0;
          m_idx = 0;
          m_produced++;
          if (GROUPS != 0 && m_produced == GROUPS) m_phase = 2;
        end
      end
      if (start) begin
        m_phase    = 1;
        m_idx      = 0;
        m_acc      = 0;
        m_produced = 0;
      end
      if (ack) m_phase = 0;
      #1;
    end
  endtask

  task automatic a_start();
    ifa.in_valid = 1'b1;
    a_cycle();
    ifa.in_valid = 1'b0;
  endtask

  task automatic a_feed(input int budget);
    for (int c = 0; c < budget && feed_q.size() > 0; c++) begin
      ifa.sIn_valid = 1'b1;
      ifa.sIn       = feed_q[0][7:0];
      a_cycle();
      if (a_fire_in) void'(feed_q.pop_front());
    end
    ifa.sIn_valid = 1'b0;
    check("feed_timeout", feed_q.size(), 0);
  endtask

  task automatic a_reset();
    rst_a = 1'b1;
    a_cycle();
    a_cycle();
    rst_a = 1'b0;
    taken_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int last_taken;
  int ov_count;
  int c_vals[3] = '{3, 4, 5};

  initial begin
    ifa.in_valid = 0; ifa.out_ready = 0; ifa.sIn = '0; ifa.sIn_valid = 0; ifa.sOut_ready = 0;
    ifc.in_valid = 0; ifc.out_ready = 0; ifc.sIn = '0; ifc.sIn_valid = 0; ifc.sOut_ready = 0;
    rst_a = 1'b1;
    rst_c = 1'b1;
    a_model_reset();
    a_reset();
    a_cycle();
    check("rst_sOut", ifa.sOut, 0);

    // Incrementing stream, output always ready.
    a_start();
    ifa.sOut_ready = 1'b1;
    for (int i = 0; i < 8; i++) feed_q.push_back(i);
    a_feed(30);
    for (int c = 0; c < 10 && !(m_phase == 2 && exp_q.size() == 0); c++) a_cycle();
    check("t1_count", taken_q.size(), 4);
    for (int i = 0; i < taken_q.size() && i < 4; i++) check("t1_sum", taken_q[i], 1 + 4 * i);
    check("t1_done", ifa.out_valid, 1);
    ifa.out_ready = 1'b1;
    a_cycle();
    ifa.out_ready = 1'b0;
    check("t1_idle", ifa.in_ready, 1);
    check("t1_ov_drop", ifa.out_valid, 0);

    // Modulo wrap.
    a_start();
    feed_q = '{200, 100};
    a_feed(10);
    a_cycle();
    a_cycle();
    last_taken = (taken_q.size() > 0) ? taken_q[taken_q.size() - 1] : -1;
    check("wrap", last_taken, 44);

    // Backpressure on the final element of the second group.
    a_reset();
    a_start();
    ifa.sOut_ready = 1'b0;
    feed_q = '{0, 1, 2, 3, 4, 5};
    for (int c = 0; c < 8; c++) begin
      ifa.sIn_valid = 1'b1;
      ifa.sIn       = feed_q[0][7:0];
      a_cycle();
      if (a_fire_in) void'(feed_q.pop_front());
    end
    check("bp_accepted", 6 - feed_q.size(), 3);
    check("bp_stall", ifa.sIn_ready, 0);
    ifa.sOut_ready = 1'b1;
    a_feed(20);
    a_cycle();
    a_cycle();
    check("bp_count", taken_q.size(), 3);
    for (int i = 0; i < taken_q.size() && i < 3; i++) check("bp_sum", taken_q[i], 1 + 4 * i);

    // Done is held off until the last sum drains.
    a_reset();
    a_start();
    ifa.sOut_ready = 1'b1;
    feed_q = '{0, 1, 2, 3, 4, 5};
    a_feed(20);
    a_cycle();
    ifa.sOut_ready = 1'b0;
    feed_q = '{6, 7};
    a_feed(10);
    for (int i = 0; i < 5; i++) begin
      a_cycle();
      check("dg_hold", ifa.out_valid, 0);
    end
    ifa.sOut_ready = 1'b1;
    a_cycle();
    ifa.sOut_ready = 1'b0;
    check("dg_rise", ifa.out_valid, 1);
    check("dg_last", taken_q.size() > 0 ? taken_q[taken_q.size() - 1] : -1, 13);
    ifa.out_ready = 1'b1;
    a_cycle();
    ifa.out_ready = 1'b0;
    check("dg_idle", ifa.in_ready, 1);

    // Reset mid-group with a sum pending, then restart.
    a_start();
    feed_q = '{1, 2, 7};
    a_feed(10);
    rst_a = 1'b1;
    a_cycle();
    rst_a = 1'b0;
    check("mr_in_ready", ifa.in_ready, 1);
    check("mr_out_valid", ifa.out_valid, 0);
    check("mr_sIn_ready", ifa.sIn_ready, 0);
    check("mr_sOut_valid", ifa.sOut_valid, 0);
    check("mr_sOut", ifa.sOut, 0);
    taken_q.delete();
    a_start();
    ifa.sOut_ready = 1'b1;
    feed_q = '{7, 8};
    a_feed(10);
    a_cycle();
    check("mr_sum", taken_q.size() > 0 ? taken_q[0] : -1, 15);

    // Randomized full runs.
    a_reset();
    for (int run = 0; run < 6; run++) begin
      a_start();
      for (int c = 0; c < 400 && m_phase != 0; c++) begin
        ifa.in_valid   = 1'($urandom_range(0, 1));
        ifa.sIn_valid  = ($urandom_range(0, 3) != 0);
        ifa.sIn        = 8'($urandom_range(0, 255));
        ifa.sOut_ready = 1'($urandom_range(0, 1));
        ifa.out_ready  = 1'($urandom_range(0, 1));
        a_cycle();
      end
      ifa.in_valid  = 1'b0;
      ifa.sIn_valid = 1'b0;
      ifa.out_ready = 1'b0;
      check("rand_timeout", m_phase, 0);
    end

    // LEN=1, GROUPS=0 instance.
    tick();
    rst_c = 1'b0;
    tick();
    check("c_rst_in_ready", ifc.in_ready, 1);
    check("c_rst_sOut_valid", ifc.sOut_valid, 0);
    ifc.in_valid = 1'b1;
    tick();
    check("c_run", ifc.in_ready, 0);
    ifc.sOut_ready = 1'b1;
    ov_count = 0;
    for (int i = 0; i < 3; i++) begin
      ifc.sIn       = 8'(c_vals[i]);
      ifc.sIn_valid = 1'b1;
      #1;
      check("c_sIn_ready", ifc.sIn_ready, 1);
      tick();
      check("c_sOut", ifc.sOut, c_vals[i]);
      check("c_sOut_valid", ifc.sOut_valid, 1);
      if (ifc.out_valid) ov_count++;
    end
    ifc.sIn_valid = 1'b0;
    tick();
    check("c_drained", ifc.sOut_valid, 0);
    for (int i = 0; i < 10; i++) begin
      ifc.out_ready = 1'b1;
      tick();
      if (ifc.out_valid) ov_count++;
    end
    ifc.in_valid = 1'b0;
    check("c_no_done", ov_count, 0);
    check("c_still_run", ifc.in_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
